char_fetch_shifter: RTL and testbench
=====================================

# char_fetch_shifter

Video character fetch-and-serialise stage for the Galaksija display path. The block accepts one character code per handshake and forms the 11-bit character ROM address. It drives the patch overlay's override request, selects either the base ROM byte or the patch byte, and shifts the result out as one pixel per pixel-clock enable. It is the consumer end of the character ROM / patch overlay interface.

## Interface
Parameters:
- none. Widths are fixed by the 2 KB character ROM: 16 rows × 128 codes × 8 bits.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_ce  in  1  pixel clock enable; one pixel is consumed per clk edge with pix_ce=1.
- char_valid  in  1  char_code/row are offered.
- char_code  in  7  character code.
- row  in  4  scanline within the character cell.
- char_ready  out  1  combinational; a transfer occurs on an edge with char_valid & char_ready.
- override_en  in  1  configuration; 1 = allow patch overlay.
- rom_a  out  11  registered ROM/patch address = {row, char_code}.
- override  out  1  registered; equals override_en captured with rom_a.
- rom_q  in  8  base ROM data; synchronous ROM, valid one edge after rom_a.
- patch_q  in  8  patch data; same timing as rom_q.
- patch_hit  in  1  patch-valid flag; same timing as rom_q.
- pixel  out  1  registered pixel; 1 = lit.
- pixel_valid  out  1  registered; 1 for one clk after each pix_ce edge that emitted a real pixel.
- underrun  out  1  sticky; set when pix_ce finds no data.
- underrun_clr  in  1  synchronous clear of underrun.

## Operation
- Pipeline valid bits s1 and s2, one holding register hold[7:0] with hold_full, shift register sr[7:0], shift count cnt[3:0] (0..7).
- char_ready = !(s1 | s2 | hold_full). Only one character is in flight or held at a time.
- Accept edge E0:
  - rom_a <= {row, char_code}.
  - override <= override_en.
  - s1 <= 1.
- E1: s1 -> s2. The ROM and the patch block register their data on this edge.
- E2, with s2=1:
  - hold <= patch_hit ? patch_q : rom_q.
  - hold_full <= 1; s2 <= 0.
- rom_a and override hold their values until the next accept.
- Each pix_ce edge takes exactly one of these branches:
  - cnt != 0: pixel <= ~sr[0]; sr <= sr >> 1; cnt <= cnt-1; pixel_valid <= 1.
  - cnt == 0 and hold_full: pixel <= ~hold[0]; sr <= hold >> 1; cnt <= 7; hold_full <= 0; pixel_valid <= 1.
  - cnt == 0 and !hold_full: pixel <= 0; pixel_valid <= 0; underrun <= 1.
- Pixel order and polarity:
  - LSB first.
  - ROM bit 0 = lit; 0xff is a blank row.
- Edges without pix_ce: pixel holds its value; pixel_valid <= 0.
- underrun_clr clears underrun. If underrun_clr and a new underrun occur on the same edge, the set wins.

## Timing
- Reset values:
  - rom_a=0, override=0.
  - s1=s2=0, hold=0xff, hold_full=0, sr=0xff, cnt=0.
  - pixel=0, pixel_valid=0, underrun=0.
- char_ready=1 while reset is asserted. Reset mid-fetch discards all in-flight and held data; no stale byte is ever emitted.
- Fetch latency: accept at E0 -> hold_full at E2. The earliest first pixel is the first pix_ce edge after E2, registered on that edge.
- No bypass:
  - A pix_ce edge coinciding with E2 sees hold_full=0.
  - If cnt=0 at that edge, it is an underrun.
- The next char_ready rises in the cycle after hold is loaded into sr.
- Sustained rate: one character per 8 pix_ce. No underrun occurs at pix_ce every clk, provided char_valid is held high.
- hold write (E2) and hold consume cannot collide: an accept requires hold_full=0.

## Test plan
- Patch path: override_en=1, row=2, code=0x27 -> rom_a=0x127, override=1 at E0. Drive patch_hit=1, patch_q=0xff, rom_q=0x00 -> 8 pixels all 0, pixel_valid high on each.
- Patch pattern: row=5, code=0x00, patch_hit=1, patch_q=0xdd -> rom_a=0x280; pixels 0,1,0,0,0,1,0,0.
- Base path: row=1, code=0x41, patch_hit=0, rom_q=0x0f, patch_q=0x00 -> rom_a=0x0c1; pixels 0,0,0,0,1,1,1,1.
- Back-to-back: pix_ce every clk, char_valid held high, codes 0x01..0x10 -> 128 contiguous valid pixels, underrun stays 0, char_ready never high while hold_full.
- Underrun: pix_ce with no accepted character -> pixel=0, pixel_valid=0, underrun=1 held. Then pulse underrun_clr -> underrun=0.
- Reset mid-operation: assert reset at E1 of a fetch -> all outputs at reset values immediately, char_ready=1. After release, next pix_ce -> underrun, not the discarded byte.

Source files
------------

// File: rtl/char_fetch_shifter_if.sv
// Character stream, ROM/patch overlay bus and pixel output of the fetch-and-serialise stage.
// The slave modport is the shifter's view; master is the surrounding video/ROM side.
interface char_fetch_shifter_if;
    logic        pix_ce;
    logic        char_valid;
    logic [6:0]  char_code;
    logic [3:0]  row;
    logic        char_ready;
    logic        override_en;
    logic [10:0] rom_a;
    logic        override;
    logic [7:0]  rom_q;
    logic [7:0]  patch_q;
    logic        patch_hit;
    logic        pixel;
    logic        pixel_valid;
    logic        underrun;
    logic        underrun_clr;

    modport slave (
        input  pix_ce, char_valid, char_code, row, override_en,
        input  rom_q, patch_q, patch_hit, underrun_clr,
        output char_ready, rom_a, override, pixel, pixel_valid, underrun
    );

    modport master (
        output pix_ce, char_valid, char_code, row, override_en,
        output rom_q, patch_q, patch_hit, underrun_clr,
        input  char_ready, rom_a, override, pixel, pixel_valid, underrun
    );
endinterface

// File: rtl/char_fetch_shifter.sv
// Galaksija character fetch and pixel serialiser: one ROM/patch byte per accepted
// character, shifted out LSB first with bit 0 = lit, one pixel per pix_ce.
module char_fetch_shifter (
    input logic                 clk,
    input logic                 reset,
    char_fetch_shifter_if.slave bus
);
    logic [10:0] rom_a_q;
    logic        override_q;
    logic        s1_q;
    logic        s2_q;
    logic [7:0]  hold_q;
    logic        hold_full_q;
    logic [7:0]  sr_q;
    logic [3:0]  cnt_q;
    logic        pixel_q;
    logic        pixel_valid_q;
    logic        underrun_q;

    logic        ready;
    logic        accept;
    logic        sr_busy;
    logic        hold_take;
    logic        starve;
    logic [7:0]  fetched;

    always_comb begin
        // Only one character may be in flight or waiting in hold at a time.
        ready     = ~(s1_q | s2_q | hold_full_q);
        accept    = bus.char_valid & ready;
        sr_busy   = (cnt_q != 4'd0);
        hold_take = bus.pix_ce & ~sr_busy & hold_full_q;
        starve    = bus.pix_ce & ~sr_busy & ~hold_full_q;
        fetched   = bus.patch_hit ? bus.patch_q : bus.rom_q;

        bus.char_ready  = ready;
        bus.rom_a       = rom_a_q;
        bus.override    = override_q;
        bus.pixel       = pixel_q;
        bus.pixel_valid = pixel_valid_q;
        bus.underrun    = underrun_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_a_q       <= 11'd0;
            override_q    <= 1'b0;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            hold_q        <= 8'hff;
            hold_full_q   <= 1'b0;
            sr_q          <= 8'hff;
            cnt_q         <= 4'd0;
            pixel_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            if (accept) begin
                rom_a_q    <= {bus.row, bus.char_code};
                override_q <= bus.override_en;
            end

            // ROM and patch register their data on the s1 edge; capture it one edge later.
            s1_q <= accept;
            s2_q <= s1_q;
            if (s2_q) begin
                hold_q <= fetched;
            end

            // A load and a take never coincide: accept requires hold_full_q low.
            if (s2_q) begin
                hold_full_q <= 1'b1;
            end else if (hold_take) begin
                hold_full_q <= 1'b0;
            end

            pixel_valid_q <= 1'b0;
            if (bus.pix_ce) begin
                if (sr_busy) begin
                    pixel_q       <= ~sr_q[0];
                    sr_q          <= {1'b0, sr_q[7:1]};
                    cnt_q         <= cnt_q - 4'd1;
                    pixel_valid_q <= 1'b1;
                end else if (hold_full_q) begin
                    pixel_q       <= ~hold_q[0];
                    sr_q          <= {1'b0, hold_q[7:1]};
                    cnt_q         <= 4'd7;
                    pixel_valid_q <= 1'b1;
                end else begin
                    pixel_q <= 1'b0;
                end
            end

            // A fresh underrun beats a simultaneous clear.
            if (starve) begin
                underrun_q <= 1'b1;
            end else if (bus.underrun_clr) begin
                underrun_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_char_fetch_shifter.sv
// Self-checking bench for char_fetch_shifter: ROM/patch memory model, per-character
// expected pixel queue, and an independent monitor comparing every emitted pixel.
module tb_char_fetch_shifter;
    logic clk;
    logic reset;

    char_fetch_shifter_if bus ();

    char_fetch_shifter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pix    = 0;
    logic exp_q[$];

    logic [7:0] rom_mem   [2048];
    logic [7:0] patch_mem [2048];
    logic       hit_mem   [2048];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous base ROM and patch overlay; the overlay only hits when override is set.
    always @(posedge clk) begin
        bus.rom_q     <= rom_mem[bus.rom_a];
        bus.patch_q   <= patch_mem[bus.rom_a];
        bus.patch_hit <= bus.override & hit_mem[bus.rom_a];
    end

    // Monitor: every valid pixel must be the next one the model predicted.
    always @(posedge clk) begin
        #1;
        if (!reset && bus.pixel_valid === 1'b1) begin
            n_pix++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pixel: got %0b expected none at %0t", bus.pixel, $time);
            end else begin
                check("pixel", 32'(bus.pixel), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; on acceptance, predict the 8 pixels and check the address.
    task automatic tick(output bit acc);
        logic [10:0] a;
        logic        ov;
        logic [7:0]  b;
        acc = (bus.char_valid === 1'b1) && (bus.char_ready === 1'b1);
        a   = {bus.row, bus.char_code};
        ov  = bus.override_en;
        @(posedge clk);
        if (acc) begin
            b = (ov && hit_mem[a]) ? patch_mem[a] : rom_mem[a];
            for (int k = 0; k < 8; k++) exp_q.push_back(~b[k]);
        end
        #1;
        if (acc) begin
            check("rom_a", 32'(bus.rom_a), 32'(a));
            check("override", 32'(bus.override), 32'(ov));
        end
    endtask

    task automatic one_char(input logic [3:0] r, input logic [6:0] c, input logic ov);
        bit acc;
        int g;
        g = 0;
        bus.char_valid  = 1'b1;
        bus.row         = r;
        bus.char_code   = c;
        bus.override_en = ov;
        do begin
            tick(acc);
            g++;
        end while (!acc && g < 20);
        bus.char_valid = 1'b0;
        check("char_accepted", 32'(acc), 32'd1);
        repeat (3) tick(acc);
        bus.pix_ce = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(acc);
            check("pixel_valid_directed", 32'(bus.pixel_valid), 32'd1);
        end
        bus.pix_ce = 1'b0;
        tick(acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timed out");
    end

    initial begin
        bit acc;
        int next;
        int warm;
        int pix_left;
        int guard;
        int pix_start;
        bit was_pix;

        for (int i = 0; i < 2048; i++) begin
            rom_mem[i]   = 8'($urandom);
            patch_mem[i] = 8'($urandom);
            hit_mem[i]   = 1'($urandom);
        end
        rom_mem[11'h127] = 8'h00; patch_mem[11'h127] = 8'hff; hit_mem[11'h127] = 1'b1;
        patch_mem[11'h280] = 8'hdd; hit_mem[11'h280] = 1'b1;
        rom_mem[11'h0c1] = 8'h0f; patch_mem[11'h0c1] = 8'h00; hit_mem[11'h0c1] = 1'b0;

        reset            = 1'b1;
        bus.pix_ce       = 1'b0;
        bus.char_valid   = 1'b0;
        bus.char_code    = 7'd0;
        bus.row          = 4'd0;
        bus.override_en  = 1'b0;
        bus.underrun_clr = 1'b0;

        #12;
        check("reset_char_ready", 32'(bus.char_ready), 32'd1);
        check("reset_rom_a", 32'(bus.rom_a), 32'd0);
        check("reset_override", 32'(bus.override), 32'd0);
        check("reset_pixel", 32'(bus.pixel), 32'd0);
        check("reset_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        check("reset_underrun", 32'(bus.underrun), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Underrun with nothing fetched, then clear, then set-beats-clear.
        bus.pix_ce = 1'b1;
        tick(acc);
        check("starve_pixel", 32'(bus.pixel), 32'd0);
        check("starve_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        check("starve_underrun", 32'(bus.underrun), 32'd1);
        bus.pix_ce = 1'b0;
        tick(acc);
        check("underrun_sticky", 32'(bus.underrun), 32'd1);
        bus.underrun_clr = 1'b1;
        tick(acc);
        check("underrun_cleared", 32'(bus.underrun), 32'd0);
        bus.pix_ce = 1'b1;
        tick(acc);
        check("underrun_set_wins", 32'(bus.underrun), 32'd1);
        bus.pix_ce       = 1'b0;
        bus.underrun_clr = 1'b0;

        // Reset asserted at E1 of a fetch discards it.
        bus.char_valid  = 1'b1;
        bus.row         = 4'd3;
        bus.char_code   = 7'h55;
        bus.override_en = 1'b1;
        tick(acc);
        bus.char_valid = 1'b0;
        check("midreset_accept", 32'(acc), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        exp_q.delete();
        check("midreset_char_ready", 32'(bus.char_ready), 32'd1);
        check("midreset_rom_a", 32'(bus.rom_a), 32'd0);
        check("midreset_override", 32'(bus.override), 32'd0);
        check("midreset_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        check("midreset_underrun", 32'(bus.underrun), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) tick(acc);
        bus.pix_ce = 1'b1;
        tick(acc);
        bus.pix_ce = 1'b0;
        check("postreset_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        check("postreset_underrun", 32'(bus.underrun), 32'd1);

        // Directed patch and base paths.
        one_char(4'd2, 7'h27, 1'b1);
        check("patch_rom_a", 32'(bus.rom_a), 32'h127);
        check("patch_override", 32'(bus.override), 32'd1);
        one_char(4'd5, 7'h00, 1'b1);
        check("pattern_rom_a", 32'(bus.rom_a), 32'h280);
        one_char(4'd1, 7'h41, 1'b0);
        check("base_rom_a", 32'(bus.rom_a), 32'h0c1);
        check("base_override", 32'(bus.override), 32'd0);
        check("directed_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back: 16 characters at pix_ce every clk, no gap, no underrun.
        bus.underrun_clr = 1'b1;
        tick(acc);
        bus.underrun_clr = 1'b0;
        bus.row          = 4'($urandom);
        bus.override_en  = 1'($urandom);
        next      = 1;
        warm      = 0;
        pix_left  = 128;
        guard     = 0;
        pix_start = n_pix;
        while (pix_left > 0 && guard < 400) begin
            bus.char_valid = (next <= 16);
            bus.char_code  = 7'(next);
            bus.pix_ce     = (warm >= 3);
            was_pix        = bus.pix_ce;
            tick(acc);
            if (acc) next++;
            if (next > 1 && warm < 3) warm++;
            if (was_pix) begin
                pix_left--;
                check("b2b_pixel_valid", 32'(bus.pixel_valid), 32'd1);
            end
            guard++;
        end
        bus.pix_ce     = 1'b0;
        bus.char_valid = 1'b0;
        check("b2b_finished", 32'(pix_left), 32'd0);
        check("b2b_underrun", 32'(bus.underrun), 32'd0);
        check("b2b_chars", 32'(next), 32'd17);
        tick(acc);
        check("b2b_pixel_count", 32'(n_pix - pix_start), 32'd128);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Randomized traffic against the memory model.
        for (int i = 0; i < 3000; i++) begin
            bus.char_valid  = ($urandom_range(0, 3) != 0);
            bus.char_code   = 7'($urandom);
            bus.row         = 4'($urandom);
            bus.override_en = 1'($urandom);
            bus.pix_ce      = ($urandom_range(0, 9) < 7);
            tick(acc);
        end
        bus.char_valid = 1'b0;
        bus.pix_ce     = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            tick(acc);
            guard++;
        end
        bus.pix_ce = 1'b0;
        tick(acc);
        check("random_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
